// File: rtl/pfvf_rtable_lookup.sv
// pfvf_rtable_lookup
//   Two-stage routing-decision pipeline in front of the PF/VF MUX. Each request carries a
//   function ID (pf, vf, vf_active) and is matched against an elaboration-time routing table.
//   The result is the destination MUX port, or DEFAULT_PORT with a miss flag.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/ready    request handshake
//   in_pf/vf          requesting function; in_vf_active selects VF (1) or PF (0) request
//   in_tag            opaque sideband, returned unchanged with the result
//   out_valid/ready   result handshake
//   out_port          selected MUX port
//   out_miss          no table entry matched
//   out_tag           tag of this result
//   miss_count        saturating count of misses accepted downstream
//   miss_count_clr    clear miss_count

package pf_vf_mux_pkg;
    typedef struct packed {
        logic [2:0]  pf;
        logic [10:0] vf;
        logic        vf_active;
        logic [3:0]  pfvf_port;
    } t_pfvf_rtable_entry;
endpackage

module pfvf_rtable_lookup #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned PF_W        = 3,
    parameter int unsigned VF_W        = 11,
    parameter int unsigned PORT_W      = 4,
    parameter int unsigned TAG_W       = 8,
    parameter logic [PORT_W-1:0] DEFAULT_PORT = '0,
    parameter pf_vf_mux_pkg::t_pfvf_rtable_entry [NUM_ENTRIES-1:0] RTABLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PF_W-1:0]   in_pf,
    input  logic [VF_W-1:0]   in_vf,
    input  logic              in_vf_active,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PORT_W-1:0] out_port,
    output logic              out_miss,
    output logic [TAG_W-1:0]  out_tag,
    output logic [15:0]       miss_count,
    input  logic              miss_count_clr
);

    // Stage 1: registered request
    logic              s1_valid;
    logic [PF_W-1:0]   s1_pf;
    logic [VF_W-1:0]   s1_vf;
    logic              s1_vf_active;
    logic [TAG_W-1:0]  s1_tag;

    logic              s2_load;
    logic              s1_advance;

    logic [NUM_ENTRIES-1:0] entry_hit;
    logic [PORT_W-1:0]      lk_port;
    logic                   lk_miss;

    logic              miss_inc;
    logic [15:0]       miss_count_d;

    assign s2_load    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !s1_valid || s1_advance;

    // All-ones table fields act as wildcards
    always_comb begin
        entry_hit = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            entry_hit[i] =
                ((PF_W'(RTABLE[i].pf) == s1_pf) || (&RTABLE[i].pf)) &&
                (RTABLE[i].vf_active == s1_vf_active) &&
                (!s1_vf_active || (VF_W'(RTABLE[i].vf) == s1_vf) || (&RTABLE[i].vf));
        end
    end

    // Scan from the top so the lowest matching index is the last (winning) assignment
    always_comb begin
        lk_port = DEFAULT_PORT;
        lk_miss = 1'b1;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (entry_hit[i]) begin
                lk_port = PORT_W'(RTABLE[i].pfvf_port);
                lk_miss = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Request payload needs no reset; it is qualified by s1_valid
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_pf        <= in_pf;
            s1_vf        <= in_vf;
            s1_vf_active <= in_vf_active;
            s1_tag       <= in_tag;
        end
    end

    // Stage 2 drives the outputs directly; payload holds its last value once drained
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_port  <= '0;
            out_miss  <= 1'b0;
            out_tag   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_port <= lk_port;
                out_miss <= lk_miss;
                out_tag  <= s1_tag;
            end
        end
    end

    // Counting on the output handshake means a stalled miss is counted exactly once
    assign miss_inc = out_valid && out_ready && out_miss;

    always_comb begin
        miss_count_d = miss_count;
        if (miss_count_clr) begin
            miss_count_d = {15'd0, miss_inc};
        end else if (miss_inc && (miss_count != 16'hFFFF)) begin
            miss_count_d = miss_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count <= 16'd0;
        end else begin
            miss_count <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_pfvf_rtable_lookup.sv
module tb_pfvf_rtable_lookup;

    localparam pf_vf_mux_pkg::t_pfvf_rtable_entry E0 =
        '{pf: 3'd0, vf: 11'd0, vf_active: 1'b0, pfvf_port: 4'd0};
    localparam pf_vf_mux_pkg::t_pfvf_rtable_entry E1 =
        '{pf: 3'd0, vf: 11'd3, vf_active: 1'b1, pfvf_port: 4'd1};
    localparam pf_vf_mux_pkg::t_pfvf_rtable_entry E2 =
        '{pf: 3'd1, vf: 11'd0, vf_active: 1'b0, pfvf_port: 4'd2};
    localparam pf_vf_mux_pkg::t_pfvf_rtable_entry E3 =
        '{pf: 3'd7, vf: 11'h7FF, vf_active: 1'b1, pfvf_port: 4'd3};
    localparam pf_vf_mux_pkg::t_pfvf_rtable_entry [3:0] TB_RTABLE = {E3, E2, E1, E0};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_pf;
    logic [10:0] in_vf;
    logic        in_vf_active;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_port;
    logic        out_miss;
    logic [7:0]  out_tag;
    logic [15:0] miss_count;
    logic        miss_count_clr;

    pfvf_rtable_lookup #(
        .NUM_ENTRIES (4),
        .PF_W        (3),
        .VF_W        (11),
        .PORT_W      (4),
        .TAG_W       (8),
        .DEFAULT_PORT(4'd0),
        .RTABLE      (TB_RTABLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pf         (in_pf),
        .in_vf         (in_vf),
        .in_vf_active  (in_vf_active),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_port      (out_port),
        .out_miss      (out_miss),
        .out_tag       (out_tag),
        .miss_count    (miss_count),
        .miss_count_clr(miss_count_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] port;
        logic       miss;
        logic [7:0] tag;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    logic [7:0]  log_tag[$];
    int          log_cyc[$];
    logic [15:0] exp_mc;
    int          cyc = 0;

    // Reference: first table entry (in index order) satisfying the matching rules
    function automatic exp_t model(input logic [2:0] pf, input logic [10:0] vf,
                                   input logic act, input logic [7:0] tag);
        exp_t r;
        pf_vf_mux_pkg::t_pfvf_rtable_entry e;
        r.port = 4'd0;
        r.miss = 1'b1;
        r.tag  = tag;
        for (int i = 0; i < 4; i++) begin
            e = TB_RTABLE[i];
            if (r.miss && (e.pf == pf || e.pf == 3'b111) && e.vf_active == act &&
                (!act || e.vf == vf || e.vf == 11'h7FF)) begin
                r.port = e.pfvf_port;
                r.miss = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] pf, input logic [10:0] vf, input logic act,
                         input logic [7:0] tag);
        bit done;
        int n;
        in_pf = pf;
        in_vf = vf;
        in_vf_active = act;
        in_tag = tag;
        in_valid = 1'b1;
        done = 0;
        n = 0;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            tick();
            n++;
            if (!done && n > 50) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({out_valid, out_miss, out_port, out_tag} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b m=%b p=%0d t=%h, required all 0",
                     out_valid, out_miss, out_port, out_tag);
        end
        checks++;
        if (miss_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_miss_count: got %h, required 0000", miss_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_lookup();
        logic [2:0]  pfs[3];
        logic [10:0] vfs[3];
        logic        acts[3];
        logic [7:0]  tags[3];
        logic [3:0]  ports[3];
        pfs = '{3'd0, 3'd0, 3'd2};
        vfs = '{11'd0, 11'd3, 11'd9};
        acts = '{1'b0, 1'b1, 1'b1};
        tags = '{8'hA5, 8'h3C, 8'h77};
        ports = '{4'd0, 4'd1, 4'd3};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(pfs[i], vfs[i], acts[i], tags[i]);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL lookup_latency_early[%0d]: out_valid=%b, required 0", i, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_port !== ports[i] || out_miss !== 1'b0 ||
                out_tag !== tags[i]) begin
                errors++;
                $display("FAIL lookup[%0d]: got v=%b p=%0d m=%b t=%h, required v=1 p=%0d m=0 t=%h",
                         i, out_valid, out_port, out_miss, out_tag, ports[i], tags[i]);
            end
            tick();
        end
    endtask

    task automatic test_miss();
        logic [15:0] base;
        base = exp_mc;
        out_ready = 1'b0;
        issue(3'd3, 11'd0, 1'b0, 8'h11);
        repeat (5) tick();
        checks++;
        if (out_valid !== 1'b1 || out_miss !== 1'b1 || out_port !== 4'd0 || out_tag !== 8'h11) begin
            errors++;
            $display("FAIL miss_held: got v=%b m=%b p=%0d t=%h, required v=1 m=1 p=0 t=11",
                     out_valid, out_miss, out_port, out_tag);
        end
        checks++;
        if (miss_count !== base) begin
            errors++;
            $display("FAIL miss_count_stalled: got %0d, required %0d", miss_count, base);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (miss_count !== base + 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_count_once: got count=%0d v=%b, required count=%0d v=0",
                     miss_count, out_valid, base + 16'd1);
        end
    endtask

    task automatic test_back_to_back();
        int accepted;
        int n;
        out_ready = 1'b1;
        log_tag.delete();
        log_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            in_pf = 3'($urandom_range(0, 7));
            in_vf = ($urandom_range(0, 1) == 1) ? 11'd3 : 11'($urandom);
            in_vf_active = 1'($urandom);
            in_tag = 8'(i);
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (log_tag.size() != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 10", log_tag.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (log_tag[i] !== 8'(i) || log_cyc[i] != log_cyc[0] + i) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got tag=%0d cyc+%0d, required tag=%0d cyc+%0d",
                             i, log_tag[i], log_cyc[i] - log_cyc[0], i, i);
                end
            end
        end

        // Stall downstream with a continuous request stream
        out_ready = 1'b0;
        log_tag.delete();
        log_cyc.delete();
        accepted = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_pf = 3'($urandom_range(0, 7));
            in_vf = 11'($urandom);
            in_vf_active = 1'($urandom);
            in_tag = 8'(20 + accepted);
            @(negedge clk);
            if (in_ready) accepted++;
            tick();
        end
        checks++;
        if (accepted != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: got accepted=%0d in_ready=%b, required 2 and 0",
                     accepted, in_ready);
        end
        out_ready = 1'b1;
        n = 0;
        while (accepted < 6 && n < 40) begin
            in_tag = 8'(20 + accepted);
            @(negedge clk);
            if (in_ready) accepted++;
            tick();
            n++;
        end
        in_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (log_tag.size() != 6) begin
            errors++;
            $display("FAIL release_count: got %0d results, required 6", log_tag.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_tag[i] !== 8'(20 + i)) begin
                    errors++;
                    $display("FAIL release_order[%0d]: got tag=%0d, required %0d",
                             i, log_tag[i], 20 + i);
                end
            end
        end
    endtask

    task automatic send_misses(input int count);
        int done;
        int n;
        done = 0;
        n = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_vf_active = 1'b0;
        while (done < count && n < count + 100) begin
            in_pf = 3'($urandom_range(2, 7));
            in_vf = 11'($urandom);
            in_tag = 8'(done);
            @(negedge clk);
            if (in_ready) done++;
            tick();
            n++;
        end
        in_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_saturate();
        int n;
        miss_count_clr = 1'b1;
        tick();
        miss_count_clr = 1'b0;
        checks++;
        if (miss_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_alone: got %h, required 0000", miss_count);
        end
        send_misses(65534);
        checks++;
        if (miss_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL count_fffe: got %h, required FFFE", miss_count);
        end
        send_misses(3);
        checks++;
        if (miss_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_saturate: got %h, required FFFF", miss_count);
        end
        out_ready = 1'b0;
        issue(3'd4, 11'd0, 1'b0, 8'hEE);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_miss !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup: got v=%b m=%b, required v=1 m=1", out_valid, out_miss);
        end
        out_ready = 1'b1;
        miss_count_clr = 1'b1;
        tick();
        miss_count_clr = 1'b0;
        checks++;
        if (miss_count !== 16'd1) begin
            errors++;
            $display("FAIL clr_with_miss: got %h, required 0001", miss_count);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        issue(3'd5, 11'd0, 1'b0, 8'h50);
        issue(3'd0, 11'd3, 1'b1, 8'h51);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || miss_count !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset: got v=%b count=%h rdy=%b, required v=0 count=0 rdy=1",
                     out_valid, miss_count, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_result[%0d]: got out_valid=%b tag=%h, required 0",
                         i, out_valid, out_tag);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] vsel[4];
        vsel = '{11'd3, 11'd9, 11'h7FF, 11'd0};
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pf = 3'($urandom_range(0, 7));
            in_vf = ($urandom_range(0, 3) == 0) ? 11'($urandom) : vsel[$urandom_range(0, 3)];
            in_vf_active = 1'($urandom);
            in_tag = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            miss_count_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        in_valid = 1'b0;
        miss_count_clr = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        exp_t       f;
        logic       stall_prev;
        logic [3:0] held_port;
        logic       held_miss;
        logic [7:0] held_tag;
        logic       inc;

        rst = 1'b1;
        in_valid = 1'b0;
        in_pf = '0;
        in_vf = '0;
        in_vf_active = 1'b0;
        in_tag = '0;
        out_ready = 1'b0;
        miss_count_clr = 1'b0;
        exp_mc = 16'd0;
        stall_prev = 1'b0;

        // Scoreboard: every result is checked against the model in request order
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (rst) begin
                    exp_q.delete();
                    exp_mc = 16'd0;
                    stall_prev = 1'b0;
                end else begin
                    checks++;
                    if (miss_count !== exp_mc) begin
                        errors++;
                        $display("FAIL mon_miss_count: got %h, required %h", miss_count, exp_mc);
                    end
                    if (stall_prev) begin
                        checks++;
                        if (out_valid !== 1'b1 || out_port !== held_port ||
                            out_miss !== held_miss || out_tag !== held_tag) begin
                            errors++;
                            $display("FAIL mon_stall_stable: got v=%b p=%0d m=%b t=%h, required v=1 p=%0d m=%b t=%h",
                                     out_valid, out_port, out_miss, out_tag,
                                     held_port, held_miss, held_tag);
                        end
                    end
                    inc = 1'b0;
                    if (out_valid === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL mon_spurious: got result tag=%h, required none", out_tag);
                        end else begin
                            f = exp_q[0];
                            if (out_port !== f.port || out_miss !== f.miss || out_tag !== f.tag) begin
                                errors++;
                                $display("FAIL mon_result: got p=%0d m=%b t=%h, required p=%0d m=%b t=%h",
                                         out_port, out_miss, out_tag, f.port, f.miss, f.tag);
                            end
                            if (out_ready) begin
                                void'(exp_q.pop_front());
                                log_tag.push_back(out_tag);
                                log_cyc.push_back(cyc);
                                inc = f.miss;
                            end
                        end
                    end
                    if (miss_count_clr) exp_mc = inc ? 16'd1 : 16'd0;
                    else if (inc && exp_mc != 16'hFFFF) exp_mc = exp_mc + 16'd1;
                    if (in_valid && in_ready) exp_q.push_back(model(in_pf, in_vf, in_vf_active, in_tag));
                    stall_prev = out_valid && !out_ready;
                    held_port = out_port;
                    held_miss = out_miss;
                    held_tag = out_tag;
                end
            end
        join_none

        test_reset();
        test_lookup();
        test_miss();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_midflight();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
